// File: rtl/s_accumulator_if.sv
// Bundle between a position producer/consumer and the signed accumulator:
// control, sample handshake and registered result.
interface s_accumulator_if #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned IN_WIDTH = 16
);
  logic                clr;
  logic                load;
  logic [WIDTH-1:0]    load_val;
  logic                in_valid;
  logic                in_ready;
  logic                in_sub;
  logic [IN_WIDTH-1:0] in_data;
  logic                out_valid;
  logic                out_ready;
  logic [WIDTH-1:0]    acc;
  logic                ovf;
  logic                ovf_sticky;

  modport master (
    output clr, load, load_val, in_valid, in_sub, in_data, out_ready,
    input  in_ready, out_valid, acc, ovf, ovf_sticky
  );

  modport slave (
    input  clr, load, load_val, in_valid, in_sub, in_data, out_ready,
    output in_ready, out_valid, acc, ovf, ovf_sticky
  );
endinterface

// File: rtl/s_accumulator.sv
// Signed running accumulator with wrap/saturate overflow handling, sticky
// overflow flag and a 1-deep registered valid/ready result.
module s_accumulator #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned IN_WIDTH = 16,
  parameter bit          SATURATE = 1'b0
) (
  input logic            clk,
  input logic            rst,
  s_accumulator_if.slave bus
);

  logic [WIDTH-1:0] r_acc;
  logic             r_ovf;
  logic             r_ovf_sticky;
  logic             r_out_valid;

  logic             w_in_ready;
  logic             w_accept;
  logic [WIDTH:0]   w_acc_ext;
  logic [WIDTH:0]   w_data_ext;
  logic [WIDTH:0]   w_sum;
  logic             w_v;
  logic [WIDTH-1:0] w_next_acc;

  // Output register drains whenever the consumer takes it, so no bubble.
  assign w_in_ready = ~r_out_valid | bus.out_ready;
  assign w_accept   = bus.in_valid & w_in_ready & ~bus.clr & ~bus.load;

  // One extra bit keeps the sum exact, including subtracting the most negative sample.
  assign w_acc_ext  = {r_acc[WIDTH-1], r_acc};
  assign w_data_ext = {{(WIDTH + 1 - IN_WIDTH){bus.in_data[IN_WIDTH-1]}}, bus.in_data};

  always_comb begin
    w_sum = bus.in_sub ? (w_acc_ext - w_data_ext) : (w_acc_ext + w_data_ext);
    w_v   = w_sum[WIDTH] ^ w_sum[WIDTH-1];
    w_next_acc = w_sum[WIDTH-1:0];
    if (SATURATE && w_v) begin
      w_next_acc = w_sum[WIDTH] ? {1'b1, {(WIDTH - 1){1'b0}}} : {1'b0, {(WIDTH - 1){1'b1}}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc        <= '0;
      r_ovf        <= 1'b0;
      r_ovf_sticky <= 1'b0;
      r_out_valid  <= 1'b0;
    end else if (bus.clr) begin
      r_acc        <= '0;
      r_ovf        <= 1'b0;
      r_ovf_sticky <= 1'b0;
      r_out_valid  <= 1'b0;
    end else if (bus.load) begin
      r_acc       <= bus.load_val;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b1;
    end else if (w_accept) begin
      r_acc        <= w_next_acc;
      r_ovf        <= w_v;
      r_ovf_sticky <= r_ovf_sticky | w_v;
      r_out_valid  <= 1'b1;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.acc        = r_acc;
  assign bus.ovf        = r_ovf;
  assign bus.ovf_sticky = r_ovf_sticky;

endmodule

// File: tb/tb_s_accumulator.sv
// Directed bench for s_accumulator: a wrapping and a saturating instance
// (WIDTH=16, IN_WIDTH=8) checked against hand-computed values.
module tb_s_accumulator;

  localparam int unsigned W  = 16;
  localparam int unsigned IW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  s_accumulator_if #(.WIDTH(W), .IN_WIDTH(IW)) ia ();
  s_accumulator_if #(.WIDTH(W), .IN_WIDTH(IW)) ib ();

  s_accumulator #(.WIDTH(W), .IN_WIDTH(IW), .SATURATE(1'b0)) u_wrap (
    .clk (clk),
    .rst (rst),
    .bus (ia.slave)
  );

  s_accumulator #(.WIDTH(W), .IN_WIDTH(IW), .SATURATE(1'b1)) u_sat (
    .clk (clk),
    .rst (rst),
    .bus (ib.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    ia.clr = 0; ia.load = 0; ia.load_val = '0; ia.in_valid = 0; ia.in_sub = 0;
    ia.in_data = '0; ia.out_ready = 1;
    ib.clr = 0; ib.load = 0; ib.load_val = '0; ib.in_valid = 0; ib.in_sub = 0;
    ib.in_data = '0; ib.out_ready = 1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    n_cmp++; if (ia.acc !== 16'h0) begin n_err++; $display("FAIL reset_acc got %h exp 0000", ia.acc); end
    n_cmp++; if (ia.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b exp 0", ia.out_valid); end
    n_cmp++; if ({ia.ovf, ia.ovf_sticky} !== 2'b00) begin n_err++; $display("FAIL reset_ovf got %b exp 00", {ia.ovf, ia.ovf_sticky}); end
    rst = 1'b0;
    #1;
    n_cmp++; if (ia.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b exp 1", ia.in_ready); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  din [3] = '{8'd5, 8'hFD, 8'd100};
    logic [15:0] exp [3] = '{16'd5, 16'd2, 16'd102};
    ia.out_ready = 1; ia.in_valid = 1; ia.in_sub = 0;
    for (int i = 0; i < 3; i++) begin
      ia.in_data = din[i];
      #1;
      n_cmp++; if (ia.in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready[%0d] got %b exp 1", i, ia.in_ready); end
      tick();
      n_cmp++; if (ia.acc !== exp[i]) begin n_err++; $display("FAIL b2b_acc[%0d] got %h exp %h", i, ia.acc, exp[i]); end
      n_cmp++; if ({ia.out_valid, ia.ovf} !== 2'b10) begin n_err++; $display("FAIL b2b_flags[%0d] got %b exp 10", i, {ia.out_valid, ia.ovf}); end
    end
    ia.in_valid = 0;
    tick();
    n_cmp++; if (ia.out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain got %b exp 0", ia.out_valid); end
  endtask

  task automatic test_wrap();
    ia.clr = 1; tick(); ia.clr = 0;
    ia.load = 1; ia.load_val = 16'h7FF0; tick(); ia.load = 0;
    n_cmp++; if ({ia.acc, ia.out_valid, ia.ovf} !== {16'h7FF0, 2'b10}) begin n_err++; $display("FAIL wrap_load got %h/%b%b exp 7ff0/10", ia.acc, ia.out_valid, ia.ovf); end
    ia.in_valid = 1; ia.in_sub = 0; ia.in_data = 8'h20; tick();
    n_cmp++; if ({ia.acc, ia.ovf, ia.ovf_sticky} !== {16'h8010, 2'b11}) begin n_err++; $display("FAIL wrap_ovf got %h/%b%b exp 8010/11", ia.acc, ia.ovf, ia.ovf_sticky); end
    ia.in_data = 8'h01; tick();
    n_cmp++; if ({ia.acc, ia.ovf, ia.ovf_sticky} !== {16'h8011, 2'b01}) begin n_err++; $display("FAIL wrap_next got %h/%b%b exp 8011/01", ia.acc, ia.ovf, ia.ovf_sticky); end
    ia.in_valid = 0; tick();
  endtask

  task automatic test_saturate();
    ib.load = 1; ib.load_val = 16'h8005; tick(); ib.load = 0;
    ib.in_valid = 1; ib.in_sub = 1; ib.in_data = 8'h7F; tick();
    n_cmp++; if ({ib.acc, ib.ovf} !== {16'h8000, 1'b1}) begin n_err++; $display("FAIL sat_neg got %h/%b exp 8000/1", ib.acc, ib.ovf); end
    ib.in_data = 8'h80; tick();
    n_cmp++; if ({ib.acc, ib.ovf, ib.ovf_sticky} !== {16'h8080, 2'b01}) begin n_err++; $display("FAIL sat_sub_min got %h/%b%b exp 8080/01", ib.acc, ib.ovf, ib.ovf_sticky); end
    ib.in_valid = 0; ib.load = 1; ib.load_val = 16'h7FF0; tick(); ib.load = 0;
    ib.in_valid = 1; ib.in_sub = 0; ib.in_data = 8'h7F; tick();
    n_cmp++; if ({ib.acc, ib.ovf} !== {16'h7FFF, 1'b1}) begin n_err++; $display("FAIL sat_pos got %h/%b exp 7fff/1", ib.acc, ib.ovf); end
    ib.in_valid = 0; tick();
  endtask

  task automatic test_handshake();
    ia.clr = 1; tick(); ia.clr = 0;
    ia.out_ready = 0; ia.in_valid = 1; ia.in_sub = 0; ia.in_data = 8'd7; tick();
    n_cmp++; if ({ia.acc, ia.out_valid, ia.in_ready} !== {16'd7, 2'b10}) begin n_err++; $display("FAIL hs_first got %h/%b%b exp 0007/10", ia.acc, ia.out_valid, ia.in_ready); end
    ia.in_data = 8'd9;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if ({ia.acc, ia.out_valid, ia.in_ready} !== {16'd7, 2'b10}) begin n_err++; $display("FAIL hs_stall[%0d] got %h/%b%b exp 0007/10", i, ia.acc, ia.out_valid, ia.in_ready); end
    end
    ia.out_ready = 1; #1;
    n_cmp++; if (ia.in_ready !== 1'b1) begin n_err++; $display("FAIL hs_release got %b exp 1", ia.in_ready); end
    tick();
    n_cmp++; if ({ia.acc, ia.out_valid} !== {16'd16, 1'b1}) begin n_err++; $display("FAIL hs_take got %h/%b exp 0010/1", ia.acc, ia.out_valid); end
    ia.in_valid = 0; tick();
  endtask

  task automatic test_clr_load();
    ia.load = 1; ia.load_val = 16'h7FFF; tick(); ia.load = 0;
    ia.in_valid = 1; ia.in_sub = 0; ia.in_data = 8'd1; tick();
    n_cmp++; if ({ia.acc, ia.ovf_sticky} !== {16'h8000, 1'b1}) begin n_err++; $display("FAIL cl_setup got %h/%b exp 8000/1", ia.acc, ia.ovf_sticky); end
    ia.load = 1; ia.load_val = 16'h0ABC; ia.in_data = 8'd5; tick();
    n_cmp++; if ({ia.acc, ia.out_valid, ia.ovf, ia.ovf_sticky} !== {16'h0ABC, 3'b101}) begin n_err++; $display("FAIL cl_load got %h/%b%b%b exp 0abc/101", ia.acc, ia.out_valid, ia.ovf, ia.ovf_sticky); end
    ia.clr = 1; tick();
    n_cmp++; if ({ia.acc, ia.out_valid, ia.ovf, ia.ovf_sticky} !== {16'h0, 3'b000}) begin n_err++; $display("FAIL cl_clr got %h/%b%b%b exp 0000/000", ia.acc, ia.out_valid, ia.ovf, ia.ovf_sticky); end
    ia.clr = 0; ia.load = 0; ia.in_valid = 0; tick();
  endtask

  task automatic test_async_reset();
    ia.load = 1; ia.load_val = 16'h0055; tick(); ia.load = 0;
    n_cmp++; if ({ia.acc, ia.out_valid} !== {16'h0055, 1'b1}) begin n_err++; $display("FAIL ar_setup got %h/%b exp 0055/1", ia.acc, ia.out_valid); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({ia.acc, ia.out_valid} !== {16'h0, 1'b0}) begin n_err++; $display("FAIL ar_async got %h/%b exp 0000/0", ia.acc, ia.out_valid); end
    tick(); rst = 1'b0; tick();
  endtask

  initial begin
    idle_all();
    test_reset();
    test_back_to_back();
    test_wrap();
    test_saturate();
    test_handshake();
    test_clr_load();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/s_accumulator.md
Name: s_accumulator

Overview:
- Parametrised signed accumulator for the Position path: the successor to the 16-bit combinational signed adder.
- Integrates signed displacement samples (e.g. encoder deltas) into a running signed position.
- Configurable accumulator/input widths, add/subtract per sample, wrap or saturate mode, sticky overflow.
- Registered result with valid/ready handshake toward the position consumer.

Parameters:
- WIDTH, 16, accumulator/result width in bits, two's complement, >= 4.
- IN_WIDTH, 16, input sample width in bits, two's complement, 2..WIDTH.
- SATURATE, 0, 0 = wrap on overflow, 1 = clamp to the signed extreme.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- clr  in  1  synchronous clear of accumulator and sticky flag.
- load  in  1  synchronous load of load_val into accumulator.
- load_val  in  WIDTH  signed preset value.
- in_valid  in  1  sample valid.
- in_ready  out  1  sample accepted when in_valid & in_ready.
- in_sub  in  1  0: acc+sample, 1: acc-sample; qualified with in_valid.
- in_data  in  IN_WIDTH  signed sample.
- out_valid  out  1  acc holds a result not yet taken.
- out_ready  in  1  consumer accepts result.
- acc  out  WIDTH  signed accumulated value (registered).
- ovf  out  1  this result overflowed (registered with acc).
- ovf_sticky  out  1  any overflow since last rst/clr.

Behaviour:
- Reset (rst=1, async): acc=0, out_valid=0, ovf=0, ovf_sticky=0. in_ready=1 once rst deasserts.
- in_ready = !out_valid | out_ready (combinational, 1-deep output register, no bubble under continuous flow).
- Priority each clock edge: clr > load > accepted sample > hold.
- clr: acc=0, ovf=0, ovf_sticky=0, out_valid=0. Any sample presented that cycle is dropped, even if in_ready=1.
- load: acc=load_val, ovf=0, out_valid=1. ovf_sticky unchanged. Concurrent sample is dropped.
- Accept (in_valid & in_ready, no clr/load):
  - Sign-extend in_data to WIDTH+1 bits, and acc to WIDTH+1 bits.
  - s = acc_ext + data_ext, or acc_ext - data_ext when in_sub=1.
  - Overflow v = s[WIDTH] ^ s[WIDTH-1].
  - SATURATE=0: acc <= s[WIDTH-1:0].
  - SATURATE=1 and v: acc <= 2^(WIDTH-1)-1 if s[WIDTH]=0, else -2^(WIDTH-1). Otherwise acc <= s[WIDTH-1:0].
  - ovf <= v; ovf_sticky <= ovf_sticky | v; out_valid <= 1.
- Latency: one clock from accept to acc/out_valid update.
- Next sample always uses the current registered acc; back-to-back accepts chain every cycle.
- out_valid clears on out_valid & out_ready when no new accept/load occurs that cycle.
- Simultaneous take and accept: out_valid stays 1 and acc takes the new value.
- Stall (out_valid=1, out_ready=0): in_ready=0; acc, ovf and out_valid hold; in_data ignored.
- Subtracting the most negative in_data is exact thanks to the WIDTH+1 intermediate; no special case.
- in_sub and in_data are don't-care when not accepted.
- rst mid-stream: immediate async clear; any in-flight result is discarded.

Test Plan (WIDTH=16, IN_WIDTH=8 unless noted):
- Reset, then accept +5, +(-3), +100 back-to-back with out_ready=1 -> acc 5, 2, 102 on successive cycles; ovf=0; in_ready held 1.
- SATURATE=0: load 0x7FF0, accept +0x20 -> acc=0x8010, ovf=1, ovf_sticky=1. Next accept +1 -> acc=0x8011, ovf=0, ovf_sticky still 1.
- SATURATE=1: load 0x8005, in_sub=1, in_data=0x7F -> acc=0x8000, ovf=1. Then in_data=-128 with in_sub=1 -> acc=0x8080, ovf=0.
- Handshake: accept 7 with out_ready=0 -> out_valid=1, in_ready=0. Hold in_valid with data 9 for 3 cycles -> acc stays 7. Raise out_ready -> 9 is accepted that cycle and acc=16 next cycle.
- clr, load and a sample in the same cycle -> acc=0, out_valid=0, ovf_sticky=0, sample dropped. load together with a sample -> acc=load_val.
- Assert rst asynchronously between edges while out_valid=1 -> acc=0, out_valid=0 immediately, before the next clk edge.
